// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - Serial bit strobe in, parallel channel words and status out
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    logic                en_i;
    logic                data_i;
    logic                sync_i;
    logic [N_CH*W-1:0]   ch_o;
    logic                valid_o;
    logic                busy_o;
    logic                err_o;

    modport master (
        output en_i, data_i, sync_i,
        input  ch_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  en_i, data_i, sync_i,
        output ch_o, valid_o, busy_o, err_o
    );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - Framed serial stream to N_CH parallel W-bit channel registers
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    tdm_demux_if.slave   bus
);
    localparam int BW  = (W > 1) ? $clog2(W) : 1;
    localparam int SW  = $clog2(N_CH);
    localparam int SHW = (W > 1) ? W - 1 : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [BW-1:0]         bit_cnt;
    logic [SW-1:0]         slot_cnt;
    logic [SHW-1:0]        sh;
    logic [(N_CH-1)*W-1:0] shadow;
    logic [N_CH*W-1:0]     ch_q;
    logic                  valid_q;
    logic                  err_q;

    logic [W-1:0]          sh_next;
    logic [BW-1:0]         bit_pos;
    logic [SW-1:0]         slot_pos;
    logic                  take;

    // Only the W-1 partial bits are kept; the word is complete the moment its last bit arrives.
    if (W > 1) begin : g_shift
        assign sh_next = {sh, bus.data_i};
    end else begin : g_single
        assign sh_next = bus.data_i;
    end

    // A sync bit is always bit 0 of slot 0, whether it opens a frame or resynchronises one.
    assign bit_pos  = bus.sync_i ? '0 : bit_cnt;
    assign slot_pos = bus.sync_i ? '0 : slot_cnt;
    assign take     = bus.en_i && (bus.sync_i || (state == SHIFT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            sh       <= '0;
            shadow   <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (take) begin
                if (bus.sync_i && (state == SHIFT)) begin
                    err_q <= 1'b1;
                end
                sh <= sh_next[SHW-1:0];
                if (bit_pos == BIT_LAST) begin
                    bit_cnt <= '0;
                    for (int k = 0; k < N_CH - 1; k++) begin
                        if (slot_pos == SW'(k)) begin
                            shadow[k*W +: W] <= sh_next;
                        end
                    end
                    if (slot_pos == SLOT_LAST) begin
                        ch_q     <= {sh_next, shadow};
                        valid_q  <= 1'b1;
                        slot_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        slot_cnt <= slot_pos + 1'b1;
                        state    <= SHIFT;
                    end
                end else begin
                    bit_cnt  <= bit_pos + 1'b1;
                    slot_cnt <= slot_pos;
                    state    <= SHIFT;
                end
            end
        end
    end

    assign bus.ch_o    = ch_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state == SHIFT);
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - Randomized and directed bench for tdm_demux against a bit-queue frame model
module tb_tdm_demux;
    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int FB   = N_CH * W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int v_cnt  = 0;

    logic [FB-1:0] m_ch    = '0;
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_err   = 1'b0;
    bit            bits[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: collect accepted bits, and on the FB-th bit slice them into MSB-first words.
    function automatic void model_step(input logic r, input logic e, input logic d, input logic s);
        if (r) begin
            m_ch = '0; m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0;
            bits.delete();
            return;
        end
        m_valid = 1'b0;
        if (!e) return;
        if (s) begin
            if (m_busy) m_err = 1'b1;
            bits.delete();
            bits.push_back(d);
            m_busy = 1'b1;
        end else if (m_busy) begin
            bits.push_back(d);
            if (bits.size() == FB) begin
                for (int k = 0; k < N_CH; k++)
                    for (int b = 0; b < W; b++)
                        m_ch[k*W + (W-1-b)] = bits[k*W + b];
                m_valid = 1'b1;
                m_busy  = 1'b0;
                bits.delete();
            end
        end
    endfunction

    task automatic check_outputs();
        chk("ch", 64'(bus.ch_o), 64'(m_ch));
        chk("valid", 64'(bus.valid_o), 64'(m_valid));
        chk("busy", 64'(bus.busy_o), 64'(m_busy));
        chk("err", 64'(bus.err_o), 64'(m_err));
        if (bus.valid_o === 1'b1) v_cnt++;
    endtask

    task automatic cycle(input logic r, input logic e, input logic d, input logic s);
        @(negedge clk);
        check_outputs();
        rst        = r;
        bus.en_i   = e;
        bus.data_i = d;
        bus.sync_i = s;
        model_step(r, e, d, s);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    // Frame value is packed like ch_o: word k at [k*W +: W], sent MSB first.
    task automatic send_range(input logic [FB-1:0] fv, input int from, input int to,
                              input bit sync_first, input int gap);
        for (int i = from; i < to; i++) begin
            repeat (gap) idle();
            cycle(1'b0, 1'b1, fv[(i / W) * W + (W - 1 - (i % W))], (i == from) && sync_first);
        end
    endtask

    logic [FB-1:0] good;
    logic [FB-1:0] other;

    initial begin
        bus.en_i   = 1'($urandom % 2);
        bus.data_i = 1'($urandom % 2);
        bus.sync_i = 1'($urandom % 2);

        // Reset with random inputs
        cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        chk("rst_ch", 64'(bus.ch_o), 64'h0);
        chk("rst_valid", 64'(bus.valid_o), 64'h0);
        chk("rst_busy", 64'(bus.busy_o), 64'h0);
        chk("rst_err", 64'(bus.err_o), 64'h0);
        idle();

        // Basic frame, strobe continuous
        send_range(32'h01FF3CA5, 0, FB, 1'b1, 0);
        idle();
        chk("basic_ch", 64'(bus.ch_o), 64'h01FF3CA5);
        chk("basic_valid", 64'(bus.valid_o), 64'h1);
        chk("basic_busy", 64'(bus.busy_o), 64'h0);
        chk("basic_err", 64'(bus.err_o), 64'h0);
        idle();
        chk("basic_valid_1clk", 64'(bus.valid_o), 64'h0);

        // Gapped strobe, from a cleared ch_o
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        v_cnt = 0;
        send_range(32'h01FF3CA5, 0, FB, 1'b1, 2);
        repeat (4) idle();
        chk("gap_ch", 64'(bus.ch_o), 64'h01FF3CA5);
        chk("gap_valid_pulses", 64'(v_cnt), 64'd1);

        // Resync error at bit 10 of a new frame
        good  = FB'($urandom);
        other = FB'($urandom);
        send_range(good, 0, FB, 1'b1, 0);
        idle();
        send_range(other, 0, 10, 1'b1, 0);
        send_range(32'h44332211, 0, 1, 1'b1, 0);
        idle();
        chk("resync_err", 64'(bus.err_o), 64'h1);
        chk("resync_ch_hold", 64'(bus.ch_o), 64'(good));
        chk("resync_busy", 64'(bus.busy_o), 64'h1);
        send_range(32'h44332211, 1, FB, 1'b0, 0);
        idle();
        chk("resync_ch", 64'(bus.ch_o), 64'h44332211);
        chk("resync_err_sticky", 64'(bus.err_o), 64'h1);

        // Reset mid-frame at bit 20
        send_range(other, 0, 20, 1'b1, 0);
        cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
        idle();
        chk("midrst_ch", 64'(bus.ch_o), 64'h0);
        chk("midrst_busy", 64'(bus.busy_o), 64'h0);
        chk("midrst_err", 64'(bus.err_o), 64'h0);
        v_cnt = 0;
        send_range(other, 20, FB, 1'b0, 0);
        repeat (2) idle();
        chk("midrst_no_valid", 64'(v_cnt), 64'd0);
        chk("midrst_ch_after", 64'(bus.ch_o), 64'h0);

        // Idle filtering
        v_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) cycle(1'b0, 1'b1, 1'($urandom % 2), 1'b0);
            else            cycle(1'b0, 1'b0, 1'($urandom % 2), 1'b1);
        end
        idle();
        chk("idle_busy", 64'(bus.busy_o), 64'h0);
        chk("idle_no_valid", 64'(v_cnt), 64'd0);

        // Random stream: gaps, back-to-back frames, occasional resync and reset
        for (int i = 0; i < 3000; i++) begin
            logic e, s, r;
            r = ($urandom % 1000) == 0;
            e = ($urandom % 3) != 0;
            s = m_busy ? (($urandom % 80) == 0) : (($urandom % 3) == 0);
            cycle(r, e, 1'($urandom % 2), s);
        end
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
